mod_counter: RTL
================

Name: mod_counter

Overview:
- Parametrised successor to the fixed 4-bit free-running counter.
- Configurable width, runtime-programmable terminal value (limit), up/down direction, synchronous load, count enable and wrap-or-saturate mode.
- Provides full/empty flags and a single-cycle wrap pulse.
- Used as the general event/timeout counter across the workshop designs.

Parameters:
- WIDTH, 4, counter and limit width in bits (>= 2).
- RESET_VALUE, 0, value of io_value after reset (must be <= 2^WIDTH-1).
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (low = in reset).
- io_clear  input  1  synchronous clear to 0, highest priority.
- io_load  input  1  synchronous load of io_loadValue.
- io_loadValue  input  WIDTH  value to load.
- io_enable  input  1  count step enable.
- io_up  input  1  direction: 1 = increment, 0 = decrement.
- io_limit  input  WIDTH  terminal count; counting range is 0..io_limit.
- io_value  output  WIDTH  current count, registered.
- io_full  output  1  combinational: io_value >= io_limit.
- io_empty  output  1  combinational: io_value == 0.
- io_wrap  output  1  registered one-cycle pulse on a wrap event.

Behaviour:
- Reset (reset low, asynchronous): io_value = RESET_VALUE, io_wrap = 0. Flags follow from io_value and io_limit.
- Next-state priority per rising clk edge:
  1. io_clear -> io_value = 0.
  2. io_load -> io_value = min(io_loadValue, io_limit).
  3. io_enable -> one step.
  4. Otherwise hold.
- io_wrap is set only in the cycle a wrap step is taken; it is 0 after any clear, load or hold cycle.
- Up step:
  - If io_value < io_limit: +1.
  - Else (full; includes io_value > io_limit after io_limit was lowered):
    - SATURATE=0: io_value = 0, io_wrap = 1 next cycle.
    - SATURATE=1: io_value = io_limit, io_wrap = 0.
- Down step:
  - If io_value > 0: -1, except when io_value > io_limit, which gives io_value = io_limit.
  - If io_value == 0:
    - SATURATE=0: io_value = io_limit, io_wrap = 1.
    - SATURATE=1: hold at 0.
- io_limit == 0: io_full and io_empty both high. Any step leaves io_value at 0. SATURATE=0 pulses io_wrap on every enabled step.
- Latency: one cycle from control input to io_value change. io_wrap coincides with the post-wrap io_value.
- Arithmetic: WIDTH bits, no carry out. io_limit = 2^WIDTH-1 gives a full-range natural counter.
- Reset asserted mid-count takes effect immediately, independent of clk. Deassertion must be synchronised externally to clk.

Optional Feature:
- Macro: MOD_COUNTER_OVERFLOW_EN.
- Defined:
  - Adds output io_overflow (1 bit, registered, reset 0).
  - Set on any wrap event, or on any enabled step blocked at a boundary in SATURATE=1.
  - Sticky until io_clear; io_clear in the same cycle as a set event wins (result 0).
  - io_load does not clear it.
- Undefined: port io_overflow and its logic absent; all other behaviour identical.

Test Plan:
- Reset/defaults: hold reset low with clk running -> io_value=RESET_VALUE(0), io_empty=1, io_wrap=0. Release; idle 5 cycles with io_enable=0 -> value unchanged.
- Wrap up: WIDTH=4, io_limit=9, io_up=1, io_enable=1 for 12 cycles from 0 -> sequence 1..9,0,1,2. io_wrap high exactly in the cycle value returns to 0. io_full high while value=9.
- Wrap down, then saturate: limit=5, io_up=0 from 1 -> 0,5,4 with io_wrap on 5. Rebuild with SATURATE=1: down from 1 -> 0,0,0, io_wrap never high.
- Priority: io_clear=1, io_load=1, io_enable=1 together with value=7 -> value=0. io_load=1 with io_loadValue=12, limit=9 -> value=9, io_full=1.
- Limit lowered: value=8, set limit=3, step up -> 0 with io_wrap=1. Repeat with io_up=0 -> value=3. limit=0 -> full=empty=1, value stays 0.
- MOD_COUNTER_OVERFLOW_EN: trigger one wrap -> io_overflow=1 and stays set through 10 further counts and a load. io_clear -> io_overflow=0 next cycle. Build without the macro -> port absent, compile clean.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: parametrised event/timeout counter.
//   - Counts 0..io_limit up or down, with synchronous clear, load and enable.
//   - SATURATE=0 wraps at the boundaries and pulses io_wrap for one cycle.
//   - SATURATE=1 holds at the boundaries.
//   - io_full and io_empty are combinational flags derived from io_value and io_limit.
// Optional feature (macro MOD_COUNTER_OVERFLOW_EN):
//   - Adds a sticky io_overflow output.
//   - It is set by any wrap event, or by any enabled step that is blocked at a
//     boundary when SATURATE=1.
//   - Only io_clear resets it.
module mod_counter #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_clear,
  input  logic             io_load,
  input  logic [WIDTH-1:0] io_loadValue,
  input  logic             io_enable,
  input  logic             io_up,
  input  logic [WIDTH-1:0] io_limit,
  output logic [WIDTH-1:0] io_value,
`ifdef MOD_COUNTER_OVERFLOW_EN
  output logic             io_overflow,
`endif
  output logic             io_full,
  output logic             io_empty,
  output logic             io_wrap
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_value;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_block;

  // Next-state selection: clear > load > enable step > hold.
  always_comb begin
    w_next  = r_value;
    w_wrap  = 1'b0;
    w_block = 1'b0;
    if (io_clear) begin
      w_next = '0;
    end else if (io_load) begin
      w_next = (io_loadValue > io_limit) ? io_limit : io_loadValue;
    end else if (io_enable) begin
      if (io_up) begin
        if (r_value < io_limit) begin
          w_next = r_value + 1'b1;
        end else if (SATURATE != 0) begin
          // Also pulls an out-of-range value (limit lowered) back to the limit.
          w_next  = io_limit;
          w_block = 1'b1;
        end else begin
          w_next = '0;
          w_wrap = 1'b1;
        end
      end else begin
        if (r_value == '0) begin
          if (SATURATE != 0) begin
            w_block = 1'b1;
          end else begin
            w_next = io_limit;
            w_wrap = 1'b1;
          end
        end else if (r_value > io_limit) begin
          w_next = io_limit;
        end else begin
          w_next = r_value - 1'b1;
        end
      end
    end
  end

  // Count register and the one-cycle wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= RST_VAL;
      r_wrap  <= 1'b0;
    end else begin
      r_value <= w_next;
      r_wrap  <= w_wrap;
    end
  end

`ifdef MOD_COUNTER_OVERFLOW_EN
  logic r_overflow;

  // Sticky overflow flag; clear wins over a simultaneous set event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (io_clear) begin
      r_overflow <= 1'b0;
    end else if (w_wrap || w_block) begin
      r_overflow <= 1'b1;
    end
  end

  assign io_overflow = r_overflow;
`endif

  assign io_value = r_value;
  assign io_wrap  = r_wrap;
  assign io_full  = (r_value >= io_limit);
  assign io_empty = (r_value == '0);

endmodule
